// File: rtl/uart_pkg.sv
// Shared types and constants for the counter UART transmitter.
// Imported by the transmitter top.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud counter: one bit_end strobe every CLKS_PER_BIT enabled cycles.
// Held at zero while the transmitter is idle.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic en,
  output logic bit_end
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_end = run & en & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!run) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/count_uart_tx.sv
// UART 8N1 transmitter for the counter value, with a one-entry
// holding register so the next byte can queue during a frame.
module count_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int DW    = UART_DATA_BITS;
  localparam int IDX_W = $clog2(DW);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DW - 1);

  uart_state_t      state_q, state_d;
  logic [DW-1:0]    hold_q, hold_d;
  logic [DW-1:0]    shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             hvld_q, hvld_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             run, accept, bit_end;

  assign run     = (state_q != IDLE);
  assign accept  = s_valid & ~hvld_q;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .en     (en),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    hvld_d  = hvld_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    if (accept) begin
      hold_d = s_data;
      hvld_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (hvld_q & en) begin
          shift_d = hold_q;
          hvld_d  = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          done_d = 1'b1;
          // Chain straight into the next frame when a byte waits.
          if (hvld_q) begin
            shift_d = hold_q;
            hvld_d  = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = UART_IDLE_LVL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      hvld_q  <= 1'b0;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= UART_IDLE_LVL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      hvld_q  <= hvld_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign s_ready    = ~hvld_q;
  assign busy       = run | hvld_q;
  assign tx         = tx_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_count_uart_tx.sv
// Bench for count_uart_tx: directed scenarios plus random bytes,
// a line decoder and a byte scoreboard.
module tb_count_uart_tx;

  localparam int CPB = 4;
  localparam int FL  = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data  = 8'h00;
  logic       s_ready, tx, busy, frame_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  byte unsigned exp_q[$];
  byte unsigned rx_q[$];
  int           fstart_q[$];
  int           flen_q[$];
  int           fd_cnt = 0;
  int           fd_cyc = 0;
  int           bitlen[10];
  bit           rnd_en = 1'b0;

  count_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Line level of frame bit i for byte b (0 start, 9 stop).
  function automatic logic fbit(input logic [7:0] b,
                                input int i);
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return b[i-1];
  endfunction

  // Line decoder: counts enabled cycles from the falling start
  // edge and samples each bit at its centre.
  int         mc, mlast, mlen;
  bit         in_fr = 1'b0;
  logic [9:0] mbits;

  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (rst) begin
      in_fr = 1'b0;
    end else begin
      if (in_fr && mc == FL) begin
        in_fr = 1'b0;
        flen_q.push_back(mlen);
      end
      if (!in_fr && tx === 1'b0) begin
        in_fr = 1'b1;
        mc    = 0;
        mlast = -1;
        mlen  = 0;
        fstart_q.push_back(cyc);
        for (int i = 0; i < 10; i++) bitlen[i] = 0;
      end
      if (in_fr) begin
        mlen++;
        bitlen[mc/CPB]++;
        if (mc != mlast) begin
          mlast = mc;
          if (mc % CPB == CPB/2) mbits[mc/CPB] = tx;
          if (mc == FL - CPB/2) begin
            chk("start_bit", mbits[0], 1'b0);
            chk("stop_bit",  mbits[9], 1'b1);
            rx_q.push_back(mbits[8:1]);
          end
        end
        if (en) mc++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_en) en = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [7:0] b, output int acc);
    int t;
    s_valid = 1'b1;
    s_data  = b;
    t = 0;
    while (!s_ready && t < 400) begin
      step();
      t++;
    end
    if (!s_ready) begin
      chk("send_timeout", s_ready, 1'b1);
      acc = -1;
    end else begin
      step();
      acc = cyc;
      exp_q.push_back(b);
    end
    s_valid = 1'b0;
    s_data  = 8'($urandom);
  endtask

  task automatic wait_rx(input int n);
    int t;
    t = 0;
    while (rx_q.size() < n && t < 3000) begin
      step();
      t++;
    end
    if (rx_q.size() < n) chk("rx_timeout", rx_q.size(), n);
  endtask

  task automatic check_data(input string tag);
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk({tag, "_byte"}, rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int a, b, c, fs, fd0;
    bit ok;
    logic [7:0] r;

    // 1: reset and idle
    idle(3);
    rst = 1'b0;
    en  = 1'b1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_ready", s_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    for (int i = 0; i < 50; i++) begin
      step();
      chk("idle_lines", {tx, s_ready, busy}, 3'b110);
    end

    // 2: single 0xA5 frame, cycle-exact waveform
    fd0 = fd_cnt;
    send(8'hA5, a);
    chk("a5_latency_tx", tx, 1'b1);
    for (int k = 1; k <= 45; k++) begin
      step();
      chk("a5_tx", tx,
          (k <= FL) ? fbit(8'hA5, (k-1)/CPB) : 1'b1);
      chk("a5_done", frame_done, (k == FL + 1));
    end
    chk("a5_done_pulses", fd_cnt - fd0, 1);
    chk("a5_done_cycle", fd_cyc, a + FL + 1);
    check_data("a5");
    idle(5);

    // 3: back-to-back 0x01, 0xFF
    fs = fstart_q.size();
    send(8'h01, a);
    send(8'hFF, b);
    chk("b2b_accept_in_f1", b < a + FL + 1, 1'b1);
    ok = 1'b1;
    while (cyc < a + 2*FL) begin
      step();
      if (busy !== 1'b1) ok = 1'b0;
    end
    chk("b2b_busy_held", ok, 1'b1);
    wait_rx(2);
    idle(6);
    chk("b2b_busy_end", busy, 1'b0);
    chk("b2b_gap", fstart_q[fs+1] - fstart_q[fs], FL);
    check_data("b2b");

    // 4: backpressure with three bytes
    send(8'h10, a);
    send(8'h20, b);
    send(8'h30, c);
    chk("bp_second_acc", b, a + 2);
    chk("bp_third_acc", c, a + FL + 2);
    wait_rx(3);
    idle(50);
    check_data("bp");

    // 5: en stall in the middle of data bit 3
    fd0 = fd_cnt;
    send(8'h3C, a);
    while (cyc < a + 18) step();
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("stall_tx", tx, fbit(8'h3C, 4));
    end
    en = 1'b1;
    c = 0;
    while (fd_cnt == fd0 && c < 200) begin
      step();
      c++;
    end
    chk("stall_done_cycle", fd_cyc, a + FL + 8);
    chk("stall_frame_len", flen_q[$], FL + 7);
    chk("stall_bit3_len", bitlen[4], CPB + 7);
    wait_rx(1);
    check_data("stall");
    idle(5);

    // 6: reset at data bit 5 with a byte pending
    send(8'h5A, a);
    send(8'h77, b);
    while (cyc < a + 26) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_tx", tx, 1'b1);
    chk("mrst_ready", s_ready, 1'b1);
    chk("mrst_busy", busy, 1'b0);
    exp_q.delete();
    rx_q.delete();
    fs = fstart_q.size();
    ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    chk("mrst_quiet", ok, 1'b1);
    chk("mrst_no_frame", fstart_q.size(), fs);
    r = 8'($urandom);
    send(r, a);
    wait_rx(1);
    idle(10);
    check_data("mrst_next");

    // 7: random bytes under random en
    rnd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      r = 8'($urandom);
      send(r, a);
    end
    wait_rx(8);
    rnd_en = 1'b0;
    en = 1'b1;
    idle(10);
    check_data("rand");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
